raw_frame_sync: RTL

Frame-alignment controller between the 5-stream AXI4-Stream combiner output (80-bit data, 60-bit channel tags) and downstream consumers (FIR / PCIe FIFO). It checks the channel tag of every lane on every beat, hunts for frame start (channel 0), and forwards only aligned 32-beat frames, marked with SOF/EOF. It resynchronises on tag errors and stops cleanly at a frame boundary when disabled. Status counters are exported for host readback.

---
 rtl/raw_frame_sync.sv | 136 +++++++++++++
 1 files changed

// File: rtl/raw_frame_sync.sv
// rtl/raw_frame_sync.sv - frame-alignment controller for the combined multi-lane sample stream
// Checks per-lane channel tags, hunts for frame start and forwards only aligned frames with SOF/EOF.
module raw_frame_sync #(
    parameter int LANES       = 5,
    parameter int CH_PER_LANE = 32,
    parameter int DATA_W      = 16,
    parameter int TAG_W       = 12
) (
    input  logic                    bus_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*DATA_W-1:0] s_data,
    input  logic [LANES*TAG_W-1:0]  s_ch,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*DATA_W-1:0] m_data,
    output logic                    m_sof,
    output logic                    m_eof,
    output logic                    locked,
    output logic [31:0]             frame_cnt,
    output logic [15:0]             err_cnt,
    output logic [15:0]             drop_cnt
);
    localparam int IDX_W = $clog2(CH_PER_LANE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_PER_LANE - 1);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCKED, S_DRAIN} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_m_valid;
    logic                      r_m_sof;
    logic                      r_m_eof;
    logic [LANES*DATA_W-1:0]   r_m_data;
    logic [31:0]               r_frame_cnt;
    logic [15:0]               r_err_cnt;
    logic [15:0]               r_drop_cnt;

    logic                      w_out_free;
    logic                      w_accept;
    logic                      w_match_idx;
    logic                      w_match_zero;
    logic [IDX_W-1:0]          w_idx_next;

    function automatic logic tags_ok(input logic [LANES*TAG_W-1:0] ch, input logic [IDX_W-1:0] i);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (ch[k*TAG_W +: TAG_W] != ({{(TAG_W-IDX_W){1'b0}}, i} + TAG_W'(k*CH_PER_LANE)))
                ok = 1'b0;
        end
        return ok;
    endfunction

    assign w_out_free   = !r_m_valid || m_ready;
    assign s_ready      = (r_state == S_IDLE || r_state == S_HUNT) ? 1'b1 : w_out_free;
    assign w_accept     = s_valid && s_ready;
    assign w_match_idx  = tags_ok(s_ch, r_idx);
    assign w_match_zero = tags_ok(s_ch, '0);
    assign w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_m_valid   <= 1'b0;
            r_m_sof     <= 1'b0;
            r_m_eof     <= 1'b0;
            r_m_data    <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (m_ready) begin
                r_m_valid <= 1'b0;
                r_m_sof   <= 1'b0;
                r_m_eof   <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (enable)
                        r_state <= S_HUNT;
                end
                S_HUNT: begin
                    // A sync beat arriving while the output register is still stalled cannot be
                    // loaded, so it is treated like any other hunted-away beat.
                    if (w_accept && w_match_zero && w_out_free) begin
                        r_m_valid <= 1'b1;
                        r_m_sof   <= 1'b1;
                        r_m_eof   <= 1'b0;
                        r_m_data  <= s_data;
                        r_idx     <= IDX_W'(1);
                        r_state   <= S_LOCKED;
                    end else begin
                        if (w_accept && r_drop_cnt != 16'hFFFF)
                            r_drop_cnt <= r_drop_cnt + 1'b1;
                        if (!enable)
                            r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (w_accept && w_match_idx) begin
                        r_m_valid <= 1'b1;
                        r_m_sof   <= (r_idx == '0);
                        r_m_eof   <= (r_idx == IDX_LAST);
                        r_m_data  <= s_data;
                        r_idx     <= w_idx_next;
                        if (r_idx == IDX_LAST)
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        // Disabling only stops at a frame boundary; otherwise finish the frame.
                        r_state <= enable ? S_LOCKED : ((w_idx_next == '0) ? S_IDLE : S_DRAIN);
                    end else if (w_accept) begin
                        if (r_err_cnt != 16'hFFFF)
                            r_err_cnt <= r_err_cnt + 1'b1;
                        r_idx   <= '0;
                        r_state <= (r_state == S_LOCKED) ? S_HUNT : S_IDLE;
                    end else begin
                        r_state <= enable ? S_LOCKED : ((r_idx == '0) ? S_IDLE : S_DRAIN);
                    end
                end
            endcase
        end
    end

    assign m_valid   = r_m_valid;
    assign m_sof     = r_m_sof;
    assign m_eof     = r_m_eof;
    assign m_data    = r_m_data;
    assign locked    = (r_state == S_LOCKED) || (r_state == S_DRAIN);
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule
